udc_pulse_driver: RTL and testbench



---
 rtl/udc_pkg.sv | 24 ++
 rtl/udc_phase_timer.sv | 36 +++
 rtl/udc_pulse_driver.sv | 165 ++++++++++++++++
 tb/tb_udc_pulse_driver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared definitions for the 74xx193 chain pulse driver: command encoding,
// FSM states and the idle level of each chain control pin.
package udc_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_INC   = 2'b01,
        OP_DEC   = 2'b10,
        OP_LOAD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_RST_HOLD,
        ST_ACTIVE,
        ST_GAP,
        ST_IDLE
    } state_e;

    localparam logic CPU_IDLE = 1'b1;
    localparam logic CPD_IDLE = 1'b1;
    localparam logic PL_IDLE  = 1'b1;
    localparam logic MR_IDLE  = 1'b0;

endpackage

// File: rtl/udc_phase_timer.sv
// Phase down-counter: loaded with (phase length - 1), flags expiry at zero
// so the owning FSM leaves the phase on the following edge.
module udc_phase_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/udc_pulse_driver.sv
// Sequencer turning clear/inc/dec/load commands into registered 74xx193 pin
// waveforms, with a shadow copy of the expected chain count and a wrap pulse.
module udc_pulse_driver
    import udc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PULSE_W = 1,
    parameter int GAP_W   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cpu,
    output logic             cpd,
    output logic             pl,
    output logic             mr,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] shadow_q,
    output logic             wrap,
    output logic             busy
);

    localparam int MAX_PHASE = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             cpu_q, cpu_d;
    logic             cpd_q, cpd_d;
    logic             pl_q, pl_d;
    logic             mr_q, mr_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] shadow_d;
    logic             wrap_q, wrap_d;

    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_expired;
    logic             pin_active;
    op_e              pin_op;

    udc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        d_d         = d_q;
        shadow_d    = shadow_q;
        wrap_d      = 1'b0;
        timer_load  = 1'b0;
        timer_val   = '0;
        pin_active  = 1'b0;
        pin_op      = op_q;
        cpu_d       = CPU_IDLE;
        cpd_d       = CPD_IDLE;
        pl_d        = PL_IDLE;
        mr_d        = MR_IDLE;

        unique case (state_q)
            ST_RST_HOLD: begin
                state_d    = ST_GAP;
                timer_load = 1'b1;
                timer_val  = GAP_LOAD;
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d    = ST_ACTIVE;
                    op_d       = op_e'(cmd_op);
                    timer_load = 1'b1;
                    timer_val  = PULSE_LOAD;
                    pin_active = 1'b1;
                    pin_op     = op_e'(cmd_op);
                    if (op_e'(cmd_op) == OP_LOAD) begin
                        d_d = cmd_data;
                    end
                end
            end
            ST_ACTIVE: begin
                if (timer_expired) begin
                    state_d    = ST_GAP;
                    timer_load = 1'b1;
                    timer_val  = GAP_LOAD;
                    // d_q already holds the load value captured at accept.
                    unique case (op_q)
                        OP_CLEAR: shadow_d = '0;
                        OP_INC: begin
                            shadow_d = shadow_q + WIDTH'(1);
                            wrap_d   = &shadow_q;
                        end
                        OP_DEC: begin
                            shadow_d = shadow_q - WIDTH'(1);
                            wrap_d   = ~|shadow_q;
                        end
                        OP_LOAD:  shadow_d = d_q;
                    endcase
                end else begin
                    pin_active = 1'b1;
                end
            end
            ST_GAP: begin
                if (timer_expired) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (pin_active) begin
            unique case (pin_op)
                OP_CLEAR: mr_d  = 1'b1;
                OP_INC:   cpu_d = 1'b0;
                OP_DEC:   cpd_d = 1'b0;
                OP_LOAD:  pl_d  = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RST_HOLD;
            op_q     <= OP_CLEAR;
            cpu_q    <= CPU_IDLE;
            cpd_q    <= CPD_IDLE;
            pl_q     <= PL_IDLE;
            mr_q     <= 1'b1;
            d_q      <= '0;
            shadow_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cpu_q    <= cpu_d;
            cpd_q    <= cpd_d;
            pl_q     <= pl_d;
            mr_q     <= mr_d;
            d_q      <= d_d;
            shadow_q <= shadow_d;
            wrap_q   <= wrap_d;
        end
    end

    assign cpu       = cpu_q;
    assign cpd       = cpd_q;
    assign pl        = pl_q;
    assign mr        = mr_q;
    assign d         = d_q;
    assign wrap      = wrap_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udc_pulse_driver.sv
// Randomized self-checking bench: a behavioural 74xx193 chain plus an
// arithmetic command model check pin waveforms, timing, shadow and wrap.
module tb_udc_pulse_driver;

    localparam int WIDTH = 8;
    localparam int PW    = 2;
    localparam int GW    = 3;
    localparam int MODV  = 1 << WIDTH;
    localparam int MASK  = MODV - 1;

    localparam logic [1:0] C_CLEAR = 2'b00;
    localparam logic [1:0] C_INC   = 2'b01;
    localparam logic [1:0] C_DEC   = 2'b10;
    localparam logic [1:0] C_LOAD  = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cpu, cpd, pl, mr, wrap, busy;
    logic [WIDTH-1:0] d, shadow_q;

    int total = 0;
    int bad   = 0;

    int exp_shadow = 0;
    int exp_d      = 0;

    udc_pulse_driver #(
        .WIDTH   (WIDTH),
        .PULSE_W (PW),
        .GAP_W   (GW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cpu       (cpu),
        .cpd       (cpd),
        .pl        (pl),
        .mr        (mr),
        .d         (d),
        .shadow_q  (shadow_q),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural cascaded 74xx193 chain driven by the DUT pins.
    logic [WIDTH-1:0] chain_q = '0;
    logic             cpu_prev = 1'b1;
    logic             cpd_prev = 1'b1;
    logic             tcd;

    always @(cpu or cpd or mr or pl or d) begin
        if (mr) begin
            chain_q = '0;
        end else if (!pl) begin
            chain_q = d;
        end else if (cpu && !cpu_prev && cpd) begin
            chain_q = chain_q + 1'b1;
        end else if (cpd && !cpd_prev && cpu) begin
            chain_q = chain_q - 1'b1;
        end
        cpu_prev = cpu;
        cpd_prev = cpd;
    end

    assign tcd = !((chain_q == '0) && !cpd);

    int cyc = 0;
    int hs_cycles[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && cmd_valid && cmd_ready) hs_cycles.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cpu_cpd_excl", {31'b0, !(cpu == 1'b0 && cpd == 1'b0)}, 32'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check(tag, {31'b0, cmd_ready}, 32'd1);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        exp_shadow = 0;
        exp_d = 0;
        step();
        check("rel_mr_low", {31'b0, mr}, 32'd0);
        check("rel_busy", {31'b0, busy}, 32'd1);
        check("rel_not_ready", {31'b0, cmd_ready}, 32'd0);
        for (int i = 1; i < GW; i++) begin
            step();
            check("rel_gap_not_ready", {31'b0, cmd_ready}, 32'd0);
        end
        step();
        check("rel_ready", {31'b0, cmd_ready}, 32'd1);
        check("rel_shadow", {24'b0, shadow_q}, 32'd0);
        check("rel_chain", {24'b0, chain_q}, 32'd0);
    endtask

    // Issue one command and follow it to the next ready cycle.
    task automatic do_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data);
        int old_v, new_v;
        bit wrap_exp;
        wait_ready("ready_timeout");
        old_v = exp_shadow;
        case (op)
            C_CLEAR: new_v = 0;
            C_INC:   new_v = (old_v + 1) % MODV;
            C_DEC:   new_v = (old_v + MODV - 1) % MODV;
            default: new_v = int'(data);
        endcase
        wrap_exp = (op == C_INC && old_v == MASK) || (op == C_DEC && old_v == 0);
        if (op == C_LOAD) exp_d = int'(data);

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = WIDTH'($urandom);

        for (int i = 0; i < PW; i++) begin
            check("act_cpu", {31'b0, cpu}, (op == C_INC) ? 32'd0 : 32'd1);
            check("act_cpd", {31'b0, cpd}, (op == C_DEC) ? 32'd0 : 32'd1);
            check("act_pl", {31'b0, pl}, (op == C_LOAD) ? 32'd0 : 32'd1);
            check("act_mr", {31'b0, mr}, (op == C_CLEAR) ? 32'd1 : 32'd0);
            check("act_d", {24'b0, d}, 32'(exp_d));
            check("act_shadow_hold", {24'b0, shadow_q}, 32'(old_v));
            check("act_busy", {30'b0, busy, cmd_ready}, 32'd2);
            if (op == C_DEC) check("act_tcd", {31'b0, tcd}, (old_v != 0) ? 32'd1 : 32'd0);
            step();
        end
        exp_shadow = new_v;
        for (int i = 0; i < GW; i++) begin
            check("gap_pins", {28'b0, cpu, cpd, pl, mr}, 32'b1110);
            check("gap_d", {24'b0, d}, 32'(exp_d));
            check("gap_shadow", {24'b0, shadow_q}, 32'(new_v));
            check("gap_wrap", {31'b0, wrap}, (i == 0 && wrap_exp) ? 32'd1 : 32'd0);
            check("gap_ready", {31'b0, cmd_ready}, 32'd0);
            step();
        end
        check("done_ready", {30'b0, busy, cmd_ready}, 32'd1);
        check("done_wrap", {31'b0, wrap}, 32'd0);
        check("done_chain", {24'b0, chain_q}, 32'(new_v));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_hs, n;
        logic [1:0] rop;
        logic [WIDTH-1:0] rdat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pins", {28'b0, cpu, cpd, pl, mr}, 32'b1111);
        check("rst_ready_busy", {30'b0, cmd_ready, busy}, 32'd1);
        check("rst_d", {24'b0, d}, 32'd0);
        check("rst_shadow", {24'b0, shadow_q}, 32'd0);
        check("rst_wrap", {31'b0, wrap}, 32'd0);
        release_reset();

        do_cmd(C_LOAD, 8'h5A);
        check("s2_load", {24'b0, shadow_q}, 32'h5A);
        do_cmd(C_INC, 8'h00);
        check("s2_inc", {24'b0, shadow_q}, 32'h5B);

        do_cmd(C_LOAD, 8'h00);
        do_cmd(C_DEC, 8'h33);
        check("s3_dec", {24'b0, chain_q}, 32'hFF);

        do_cmd(C_LOAD, 8'hFF);
        do_cmd(C_INC, 8'h00);
        check("s4_inc", {24'b0, chain_q}, 32'h00);

        do_cmd(C_CLEAR, 8'hAA);

        // Streamed INCs with cmd_valid held high
        start_hs = hs_cycles.size();
        cmd_valid = 1'b1;
        cmd_op = C_INC;
        n = 0;
        while (hs_cycles.size() - start_hs < 10 && n < 200) begin
            step();
            n++;
        end
        cmd_valid = 1'b0;
        check("s5_hs_count", 32'(hs_cycles.size() - start_hs), 32'd10);
        for (int i = start_hs + 1; i < hs_cycles.size(); i++) begin
            check("s5_spacing", 32'(hs_cycles[i] - hs_cycles[i-1]), 32'(PW + GW + 1));
        end
        wait_ready("s5_ready_timeout");
        exp_shadow = (exp_shadow + 10) % MODV;
        check("s5_shadow", {24'b0, shadow_q}, 32'(exp_shadow));
        check("s5_chain", {24'b0, chain_q}, 32'(exp_shadow));

        // Reset in the middle of an INC pulse
        do_cmd(C_LOAD, 8'h10);
        cmd_valid = 1'b1;
        cmd_op = C_INC;
        step();
        cmd_valid = 1'b0;
        check("s6_cpu_active", {31'b0, cpu}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("s6_rst_pins", {28'b0, cpu, cpd, pl, mr}, 32'b1111);
        check("s6_rst_shadow", {24'b0, shadow_q}, 32'd0);
        check("s6_rst_ready", {31'b0, cmd_ready}, 32'd0);
        check("s6_rst_chain", {24'b0, chain_q}, 32'd0);
        step();
        step();
        release_reset();

        // Randomized command mix
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) step();
            rop  = 2'($urandom_range(0, 3));
            rdat = WIDTH'($urandom);
            if (rop == C_LOAD && $urandom_range(0, 2) == 0) rdat = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            do_cmd(rop, rdat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
